// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dMem read arbiter: source encoding and default widths.
package dmem_arb_pkg;

    typedef enum logic {
        SRC_MISS = 1'b0,
        SRC_UC   = 1'b1
    } src_e;

    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned ADDR_W_DEF = 40;
    localparam int unsigned ID_W_DEF   = 4;
    localparam int unsigned LEN_W_DEF  = 8;
    localparam int unsigned SIZE_W_DEF = 3;
    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned DEPTH_DEF  = 4;

    function automatic src_e other_src(src_e s);
        return src_e'(~s);
    endfunction

endpackage

// File: rtl/dmem_arb_order_fifo.sv
// DEPTH x 1-bit order FIFO recording which source owns each outstanding transaction.
module dmem_arb_order_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  logic           push_data_i,
    input  logic           pop_i,
    output logic           head_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] count_o
);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    // Pointers are log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_read_arbiter.sv
// Two-source round-robin read arbiter with grant lock and in-order response steering.
module dmem_read_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned ID_W   = ID_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned SIZE_W = SIZE_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_SRC-1:0]     req_valid_i,
    output logic [NUM_SRC-1:0]     req_ready_o,
    input  logic [ADDR_W-1:0]      req_addr_i [NUM_SRC],
    input  logic [LEN_W-1:0]       req_len_i  [NUM_SRC],
    input  logic [SIZE_W-1:0]      req_size_i [NUM_SRC],
    input  logic [ID_W-1:0]        req_id_i   [NUM_SRC],
    output logic                   dn_req_valid_o,
    input  logic                   dn_req_ready_i,
    output logic [ADDR_W-1:0]      dn_req_addr_o,
    output logic [LEN_W-1:0]       dn_req_len_o,
    output logic [SIZE_W-1:0]      dn_req_size_o,
    output logic [ID_W-1:0]        dn_req_id_o,
    input  logic                   dn_resp_valid_i,
    output logic                   dn_resp_ready_o,
    input  logic [DATA_W-1:0]      dn_resp_data_i,
    input  logic [ID_W-1:0]        dn_resp_id_i,
    input  logic                   dn_resp_last_i,
    output logic [NUM_SRC-1:0]     resp_valid_o,
    input  logic [NUM_SRC-1:0]     resp_ready_i,
    output logic [DATA_W-1:0]      resp_data_o,
    output logic [ID_W-1:0]        resp_id_o,
    output logic                   resp_last_o,
    output logic [$clog2(DEPTH):0] outstanding_o,
    output logic                   err_o
);

    src_e r_rr;
    logic r_lock;
    src_e r_lock_src;
    logic r_err;

    src_e w_grant;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_dn_valid;
    logic w_push;
    logic w_pop;

    always_comb begin
        w_grant = SRC_MISS;
        if (r_lock) begin
            w_grant = r_lock_src;
        end else if (&req_valid_i) begin
            w_grant = r_rr;
        end else if (req_valid_i[SRC_UC]) begin
            w_grant = SRC_UC;
        end
    end

    assign w_dn_valid     = ~rst_i & ~w_full & req_valid_i[w_grant];
    assign w_push         = w_dn_valid & dn_req_ready_i;
    assign dn_req_valid_o = w_dn_valid;
    assign dn_req_addr_o  = req_addr_i[w_grant];
    assign dn_req_len_o   = req_len_i[w_grant];
    assign dn_req_size_o  = req_size_i[w_grant];
    assign dn_req_id_o    = req_id_i[w_grant];

    always_comb begin
        req_ready_o          = '0;
        req_ready_o[w_grant] = ~rst_i & ~w_full & dn_req_ready_i;
    end

    // With nothing outstanding, stray beats are accepted and dropped.
    always_comb begin
        resp_valid_o    = '0;
        dn_resp_ready_o = 1'b0;
        if (!rst_i) begin
            if (w_empty) begin
                dn_resp_ready_o = 1'b1;
            end else begin
                resp_valid_o[w_head] = dn_resp_valid_i;
                dn_resp_ready_o      = resp_ready_i[w_head];
            end
        end
    end

    assign w_pop       = ~w_empty & dn_resp_valid_i & resp_ready_i[w_head] & dn_resp_last_i;
    assign resp_data_o = dn_resp_data_i;
    assign resp_id_o   = dn_resp_id_i;
    assign resp_last_o = dn_resp_last_i;
    assign err_o       = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr       <= SRC_MISS;
            r_lock     <= 1'b0;
            r_lock_src <= SRC_MISS;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr   <= other_src(w_grant);
                r_lock <= 1'b0;
            end else if (w_dn_valid) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_grant;
            end
            if (dn_resp_valid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    dmem_arb_order_fifo #(
        .DEPTH(DEPTH)
    ) u_order_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_push),
        .push_data_i(w_grant),
        .pop_i      (w_pop),
        .head_o     (w_head),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .count_o    (outstanding_o)
    );

endmodule

// File: tb/tb_dmem_read_arbiter.sv
// Self-checking bench for dmem_read_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_dmem_read_arbiter;

    localparam int ADDR_W = 40;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr [2];
    logic [LEN_W-1:0]  req_len  [2];
    logic [SIZE_W-1:0] req_size [2];
    logic [ID_W-1:0]   req_id   [2];
    logic              dn_req_valid;
    logic              dn_req_ready;
    logic [ADDR_W-1:0] dn_req_addr;
    logic [LEN_W-1:0]  dn_req_len;
    logic [SIZE_W-1:0] dn_req_size;
    logic [ID_W-1:0]   dn_req_id;
    logic              dn_resp_valid;
    logic              dn_resp_ready;
    logic [DATA_W-1:0] dn_resp_data;
    logic [ID_W-1:0]   dn_resp_id;
    logic              dn_resp_last;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [ID_W-1:0]   resp_id;
    logic              resp_last;
    logic [2:0]        outstanding;
    logic              err;

    int n_checks;
    int n_errors;

    // Reference model: queue of owning sources, last served source, held-off request, error.
    int m_q[$];
    int m_last;
    int m_pend;
    bit m_err;

    dmem_read_arbiter #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W),
        .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_len_i      (req_len),
        .req_size_i     (req_size),
        .req_id_i       (req_id),
        .dn_req_valid_o (dn_req_valid),
        .dn_req_ready_i (dn_req_ready),
        .dn_req_addr_o  (dn_req_addr),
        .dn_req_len_o   (dn_req_len),
        .dn_req_size_o  (dn_req_size),
        .dn_req_id_o    (dn_req_id),
        .dn_resp_valid_i(dn_resp_valid),
        .dn_resp_ready_o(dn_resp_ready),
        .dn_resp_data_i (dn_resp_data),
        .dn_resp_id_i   (dn_resp_id),
        .dn_resp_last_i (dn_resp_last),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_data_o    (resp_data),
        .resp_id_o      (resp_id),
        .resp_last_o    (resp_last),
        .outstanding_o  (outstanding),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_last = 1;
        m_pend = -1;
        m_err  = 1'b0;
    endtask

    function automatic bit m_full();
        return m_q.size() == DEPTH;
    endfunction

    // A held-off request keeps the grant; else contention alternates away from the last winner.
    function automatic int exp_grant();
        if (m_pend >= 0) return m_pend;
        if (req_valid == 2'b11) return 1 - m_last;
        if (req_valid[1]) return 1;
        return 0;
    endfunction

    task automatic tick();
        int  g;
        bit  dv, acc, pop, errset;
        g      = exp_grant();
        dv     = !m_full() && req_valid[g];
        acc    = dv && dn_req_ready;
        pop    = (m_q.size() > 0) && dn_resp_valid && resp_ready[m_q[0]] && dn_resp_last;
        errset = dn_resp_valid && (m_q.size() == 0);
        @(posedge clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_q.push_back(g);
            m_last = g;
            m_pend = -1;
        end else if (dv) begin
            m_pend = g;
        end
        if (errset) m_err = 1'b1;
    endtask

    task automatic idle_inputs();
        req_valid     = 2'b00;
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        dn_resp_data  = '0;
        dn_resp_id    = '0;
        dn_resp_last  = 1'b0;
        resp_ready    = 2'b00;
        for (int s = 0; s < 2; s++) begin
            req_addr[s] = '0;
            req_len[s]  = '0;
            req_size[s] = '0;
            req_id[s]   = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst           = 1'b1;
        req_valid     = 2'b11;
        dn_req_ready  = 1'b1;
        resp_ready    = 2'b11;
        dn_resp_valid = 1'b1;
        #2;
        n_checks += 6;
        if (dn_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_dn_req_valid got %b want 0", dn_req_valid);
        end
        if (req_ready !== 2'b00) begin
            n_errors++; $display("FAIL reset_req_ready got %b want 00", req_ready);
        end
        if (resp_valid !== 2'b00) begin
            n_errors++; $display("FAIL reset_resp_valid got %b want 00", resp_valid);
        end
        if (dn_resp_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_dn_resp_ready got %b want 0", dn_resp_ready);
        end
        if (outstanding !== 3'd0) begin
            n_errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding);
        end
        if (err !== 1'b0) begin
            n_errors++; $display("FAIL reset_err got %b want 0", err);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] d;
        do_reset();
        req_valid    = 2'b01;
        req_addr[0]  = 40'h80_0000_40;
        req_addr[0]  = 40'h0080000040;
        req_id[0]    = 4'd3;
        req_len[0]   = 8'd1;
        req_size[0]  = 3'd4;
        req_addr[1]  = 40'h1234;
        dn_req_ready = 1'b1;
        #2;
        n_checks += 4;
        if (dn_req_valid !== 1'b1) begin
            n_errors++; $display("FAIL single_dn_valid got %b want 1", dn_req_valid);
        end
        if (dn_req_addr !== 40'h0080000040) begin
            n_errors++; $display("FAIL single_addr got %h want 0080000040", dn_req_addr);
        end
        if (dn_req_id !== 4'd3 || dn_req_len !== 8'd1) begin
            n_errors++; $display("FAIL single_id_len got %h/%h want 3/01", dn_req_id, dn_req_len);
        end
        if (req_ready !== 2'b01) begin
            n_errors++; $display("FAIL single_req_ready got %b want 01", req_ready);
        end
        tick();
        req_valid    = 2'b00;
        dn_req_ready = 1'b0;
        n_checks++;
        if (outstanding !== 3'd1) begin
            n_errors++; $display("FAIL single_outstanding_1 got %0d want 1", outstanding);
        end
        for (int b = 0; b < 2; b++) begin
            d             = {$urandom, $urandom, $urandom, $urandom};
            dn_resp_valid = 1'b1;
            dn_resp_data  = d;
            dn_resp_id    = 4'd3;
            dn_resp_last  = (b == 1);
            resp_ready    = 2'b01;
            #2;
            n_checks += 3;
            if (resp_valid !== 2'b01) begin
                n_errors++; $display("FAIL single_resp_valid got %b want 01", resp_valid);
            end
            if (resp_id !== 4'd3 || resp_data !== d) begin
                n_errors++; $display("FAIL single_resp_fields got %h/%h want 3/%h",
                                     resp_id, resp_data, d);
            end
            if (dn_resp_ready !== 1'b1) begin
                n_errors++; $display("FAIL single_dn_resp_ready got %b want 1", dn_resp_ready);
            end
            tick();
            n_checks++;
            if (outstanding !== ((b == 0) ? 3'd1 : 3'd0)) begin
                n_errors++; $display("FAIL single_outstanding_beat%0d got %0d want %0d",
                                     b, outstanding, (b == 0) ? 1 : 0);
            end
        end
        dn_resp_valid = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++; $display("FAIL single_err got %b want 0", err);
        end
    endtask

    task automatic test_contention();
        logic [1:0] e;
        do_reset();
        req_valid    = 2'b11;
        dn_req_ready = 1'b1;
        req_addr[0]  = 40'h100;
        req_addr[1]  = 40'h101;
        for (int k = 0; k < 4; k++) begin
            e          = 2'b00;
            e[k % 2]   = 1'b1;
            #2;
            n_checks += 2;
            if (req_ready !== e) begin
                n_errors++; $display("FAIL contention_grant%0d got %b want %b", k, req_ready, e);
            end
            if (dn_req_addr !== req_addr[k % 2]) begin
                n_errors++; $display("FAIL contention_addr%0d got %h want %h",
                                     k, dn_req_addr, req_addr[k % 2]);
            end
            tick();
        end
        req_valid    = 2'b00;
        dn_req_ready = 1'b0;
        n_checks++;
        if (outstanding !== 3'd4) begin
            n_errors++; $display("FAIL contention_outstanding got %0d want 4", outstanding);
        end
        for (int k = 0; k < 4; k++) begin
            dn_resp_valid = 1'b1;
            dn_resp_last  = 1'b1;
            dn_resp_id    = 4'(k);
            resp_ready    = 2'b11;
            e             = 2'b00;
            e[k % 2]      = 1'b1;
            #2;
            n_checks++;
            if (resp_valid !== e) begin
                n_errors++; $display("FAIL contention_resp%0d got %b want %b", k, resp_valid, e);
            end
            tick();
        end
        dn_resp_valid = 1'b0;
        n_checks++;
        if (outstanding !== 3'd0) begin
            n_errors++; $display("FAIL contention_drain got %0d want 0", outstanding);
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_addr[1]  = 40'hAB_CDEF_0000;
        req_id[1]    = 4'd5;
        req_addr[0]  = 40'h00_0000_2000;
        req_id[0]    = 4'd9;
        req_valid    = 2'b10;
        dn_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) req_valid = 2'b11;
            #2;
            n_checks += 3;
            if (dn_req_valid !== 1'b1) begin
                n_errors++; $display("FAIL lock_valid_c%0d got %b want 1", c, dn_req_valid);
            end
            if (dn_req_addr !== 40'hAB_CDEF_0000 || dn_req_id !== 4'd5) begin
                n_errors++; $display("FAIL lock_fields_c%0d got %h/%h want abcdef0000/5",
                                     c, dn_req_addr, dn_req_id);
            end
            if (req_ready !== 2'b00) begin
                n_errors++; $display("FAIL lock_ready_c%0d got %b want 00", c, req_ready);
            end
            tick();
        end
        dn_req_ready = 1'b1;
        #2;
        n_checks++;
        if (req_ready !== 2'b10 || dn_req_addr !== 40'hAB_CDEF_0000) begin
            n_errors++; $display("FAIL lock_accept got %b/%h want 10/abcdef0000",
                                 req_ready, dn_req_addr);
        end
        tick();
        #2;
        n_checks++;
        if (req_ready !== 2'b01 || dn_req_id !== 4'd9) begin
            n_errors++; $display("FAIL lock_next_miss got %b/%h want 01/9", req_ready, dn_req_id);
        end
        tick();
    endtask

    task automatic test_full();
        logic [1:0] e;
        do_reset();
        req_valid    = 2'b01;
        dn_req_ready = 1'b1;
        repeat (4) tick();
        req_valid = 2'b11;
        #2;
        n_checks += 2;
        if (outstanding !== 3'd4) begin
            n_errors++; $display("FAIL full_outstanding got %0d want 4", outstanding);
        end
        if (req_ready !== 2'b00 || dn_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL full_blocked got %b/%b want 00/0", req_ready, dn_req_valid);
        end
        dn_resp_valid = 1'b1;
        dn_resp_last  = 1'b1;
        resp_ready    = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b00 || dn_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL full_pop_no_push got %b/%b want 00/0",
                                 req_ready, dn_req_valid);
        end
        tick();
        dn_resp_valid = 1'b0;
        e             = 2'b00;
        e[exp_grant()] = 1'b1;
        #2;
        n_checks += 2;
        if (outstanding !== 3'd3) begin
            n_errors++; $display("FAIL full_after_pop got %0d want 3", outstanding);
        end
        if (req_ready !== e) begin
            n_errors++; $display("FAIL full_resume got %b want %b", req_ready, e);
        end
        tick();
        n_checks++;
        if (outstanding !== 3'd4) begin
            n_errors++; $display("FAIL full_refill got %0d want 4", outstanding);
        end
    endtask

    task automatic test_resp_backpressure();
        logic [DATA_W-1:0] d;
        do_reset();
        req_valid    = 2'b10;
        dn_req_ready = 1'b1;
        tick();
        req_valid     = 2'b00;
        dn_req_ready  = 1'b0;
        d             = {$urandom, $urandom, $urandom, $urandom};
        dn_resp_valid = 1'b1;
        dn_resp_data  = d;
        dn_resp_id    = 4'd7;
        dn_resp_last  = 1'b1;
        resp_ready    = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_checks += 2;
            if (dn_resp_ready !== 1'b0 || resp_valid !== 2'b10) begin
                n_errors++; $display("FAIL bp_hold_c%0d got %b/%b want 0/10",
                                     c, dn_resp_ready, resp_valid);
            end
            if (resp_data !== d) begin
                n_errors++; $display("FAIL bp_data_c%0d got %h want %h", c, resp_data, d);
            end
            tick();
            n_checks++;
            if (outstanding !== 3'd1) begin
                n_errors++; $display("FAIL bp_no_pop_c%0d got %0d want 1", c, outstanding);
            end
        end
        resp_ready = 2'b10;
        #2;
        n_checks++;
        if (dn_resp_ready !== 1'b1) begin
            n_errors++; $display("FAIL bp_release got %b want 1", dn_resp_ready);
        end
        tick();
        dn_resp_valid = 1'b0;
        n_checks++;
        if (outstanding !== 3'd0) begin
            n_errors++; $display("FAIL bp_pop got %0d want 0", outstanding);
        end
    endtask

    task automatic test_error_reset();
        do_reset();
        dn_resp_valid = 1'b1;
        dn_resp_last  = 1'b0;
        #2;
        n_checks++;
        if (dn_resp_ready !== 1'b1 || resp_valid !== 2'b00) begin
            n_errors++; $display("FAIL err_drop got %b/%b want 1/00", dn_resp_ready, resp_valid);
        end
        tick();
        dn_resp_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++; $display("FAIL err_set got %b want 1", err);
        end
        req_valid    = 2'b01;
        dn_req_ready = 1'b1;
        tick();
        req_valid     = 2'b00;
        dn_resp_valid = 1'b1;
        resp_ready    = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        n_checks += 2;
        if (err !== 1'b0 || outstanding !== 3'd0) begin
            n_errors++; $display("FAIL err_async_clear got %b/%0d want 0/0", err, outstanding);
        end
        if (dn_resp_ready !== 1'b0 || resp_valid !== 2'b00) begin
            n_errors++; $display("FAIL err_reset_outputs got %b/%b want 0/00",
                                 dn_resp_ready, resp_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        dn_resp_valid = 1'b0;
        req_valid     = 2'b11;
        dn_req_ready  = 1'b0;
        #2;
        n_checks++;
        if (dn_req_valid !== 1'b1 || dn_req_addr !== req_addr[0]) begin
            n_errors++; $display("FAIL err_rr_cleared got %b/%h want 1/%h",
                                 dn_req_valid, dn_req_addr, req_addr[0]);
        end
        req_valid     = 2'b00;
        dn_resp_valid = 1'b1;
        tick();
        dn_resp_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++; $display("FAIL err_after_reset got %b want 1", err);
        end
    endtask

    task automatic test_random();
        int         g;
        bit         dv;
        logic [1:0] e;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                if (m_pend == s) begin
                    req_valid[s] = 1'b1;
                end else begin
                    req_valid[s] = ($urandom_range(0, 2) != 0);
                    req_addr[s]  = {8'($urandom), $urandom};
                    req_len[s]   = 8'($urandom);
                    req_size[s]  = 3'($urandom);
                    req_id[s]    = 4'($urandom);
                end
            end
            dn_req_ready  = ($urandom_range(0, 3) != 0);
            dn_resp_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            dn_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            dn_resp_id    = 4'($urandom);
            dn_resp_last  = ($urandom_range(0, 1) == 1);
            resp_ready    = 2'($urandom);
            #2;
            g  = exp_grant();
            dv = !m_full() && req_valid[g];
            n_checks += 4;
            if (dn_req_valid !== dv) begin
                n_errors++; $display("FAIL rnd_dn_valid c%0d got %b want %b", cyc, dn_req_valid, dv);
            end
            if (req_valid != 2'b00 || m_pend >= 0) begin
                e = 2'b00;
                if (!m_full() && dn_req_ready) e[g] = 1'b1;
                n_checks++;
                if (req_ready !== e) begin
                    n_errors++; $display("FAIL rnd_req_ready c%0d got %b want %b",
                                         cyc, req_ready, e);
                end
            end
            if (dv) begin
                n_checks++;
                if (dn_req_addr !== req_addr[g] || dn_req_len !== req_len[g] ||
                    dn_req_size !== req_size[g] || dn_req_id !== req_id[g]) begin
                    n_errors++; $display("FAIL rnd_dn_fields c%0d got %h/%h want src %0d %h/%h",
                                         cyc, dn_req_addr, dn_req_id, g, req_addr[g], req_id[g]);
                end
            end
            e = 2'b00;
            if (m_q.size() > 0) e[m_q[0]] = dn_resp_valid;
            if (resp_valid !== e) begin
                n_errors++; $display("FAIL rnd_resp_valid c%0d got %b want %b", cyc, resp_valid, e);
            end
            if (dn_resp_ready !== ((m_q.size() == 0) ? 1'b1 : resp_ready[m_q[0]])) begin
                n_errors++; $display("FAIL rnd_dn_resp_ready c%0d got %b", cyc, dn_resp_ready);
            end
            if (resp_data !== dn_resp_data || resp_id !== dn_resp_id ||
                resp_last !== dn_resp_last) begin
                n_errors++; $display("FAIL rnd_resp_passthru c%0d got %h/%b want %h/%b",
                                     cyc, resp_id, resp_last, dn_resp_id, dn_resp_last);
            end
            tick();
            n_checks += 2;
            if (outstanding !== 3'(m_q.size())) begin
                n_errors++; $display("FAIL rnd_outstanding c%0d got %0d want %0d",
                                     cyc, outstanding, m_q.size());
            end
            if (err !== m_err) begin
                n_errors++; $display("FAIL rnd_err c%0d got %b want %b", cyc, err, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_full();
        test_resp_backpressure();
        test_error_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_read_arbiter.md
# dmem_read_arbiter

Shares one downstream read-request/read-response channel between the two data-cache read sources of the tile: the miss-read port (source 0) and the uncached-read port (source 1). It sits between the core tile's dMem read interfaces and the L2 / memory model. Requests are arbitrated round-robin with a grant lock. The source of every accepted request is recorded in an order FIFO so that in-order, multi-beat responses are steered back to the correct requester.

## Interface
- `ADDR_W`, default 40: physical address width (`drac_pkg::PHY_ADDR_SIZE`).
- `ID_W`, default 4: transaction ID width; passed through unchanged.
- `LEN_W`, default 8 / `SIZE_W`, default 3: burst length and beat size fields; passed through.
- `DATA_W`, default 128: response data width (`drac_pkg::DCACHE_BUS_WIDTH`).
- `DEPTH`, default 4: outstanding-transaction limit; a power of 2, at least 2.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_valid_i[2]`, `req_ready_o[2]`: per-source request handshake; index 0 = miss, 1 = uc.
- `req_addr_i[2]` in ADDR_W, `req_len_i[2]` in LEN_W, `req_size_i[2]` in SIZE_W, `req_id_i[2]` in ID_W: per-source request fields.
- `dn_req_valid_o` out 1, `dn_req_ready_i` in 1, `dn_req_addr_o`, `dn_req_len_o`, `dn_req_size_o`, `dn_req_id_o`: merged downstream request.
- `dn_resp_valid_i` in 1, `dn_resp_ready_o` out 1, `dn_resp_data_i` in DATA_W, `dn_resp_id_i` in ID_W, `dn_resp_last_i` in 1: downstream response.
- `resp_valid_o[2]`, `resp_ready_i[2]`, `resp_data_o` DATA_W, `resp_id_o` ID_W, `resp_last_o` 1: response back to the sources; data/id/last are shared, and valid is one-hot.
- `outstanding_o` out clog2(DEPTH)+1: FIFO occupancy.
- `err_o` out 1: sticky protocol-error flag.

## Operation
- Arbiter state: `rr_q`, which names the source with priority next; `lock_q`/`lock_src_q`, which hold the grant while a downstream request is pending.
- The grant is taken only when the order FIFO is not full.
  - If `lock_q` is set, the grant goes to `lock_src_q`.
  - Otherwise, when both sources request, the grant goes to the `rr_q` source; when only one source requests, it goes to that source.
- `dn_req_*` is muxed from the granted source. `dn_req_valid_o` equals the granted source's valid. `req_ready_o[g]` equals `dn_req_ready_i` (and FIFO not full); the non-granted ready is 0.
- When `dn_req_valid_o & ~dn_req_ready_i`, set `lock_q` and `lock_src_q = g`. This keeps the downstream request stable until it is accepted.
- On acceptance (`dn_req_valid_o & dn_req_ready_i`):
  - push `g` into the FIFO;
  - `rr_q <= ~g`;
  - clear `lock_q`.
- Response steering:
  - FIFO head `h`: `resp_valid_o[h] = dn_resp_valid_i` and `dn_resp_ready_o = resp_ready_i[h]`.
  - On a handshake with `dn_resp_last_i = 1`, pop the FIFO. Beats without last do not pop.
- Error: `dn_resp_valid_i` while the FIFO is empty sets `err_o` until reset. In that case `dn_resp_ready_o = 1`, so the beat is dropped, and `resp_valid_o = 0`.

## Timing
- Reset values: `rr_q = 0`, `lock_q = 0`, FIFO empty, `outstanding_o = 0`, `err_o = 0`. During reset all valid/ready outputs are 0.
- Request path: zero-cycle combinational pass-through. Acceptance updates state at the next clock edge.
- Response path: zero-cycle combinational, from the registered FIFO head.
- Full FIFO: both `req_ready_o` are 0 and `dn_req_valid_o` is 0. A pop in the same cycle does not enable a push; push resumes the cycle after.
- Simultaneous push and pop when not full: occupancy is unchanged, and the head advances correctly. With a single entry, the new entry becomes head the next cycle.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is one bit wider, to distinguish full from empty.
- Reset mid-burst: all state clears asynchronously. Any response beat arriving afterward raises `err_o`.

## Structure
- A shared package `dmem_arb_pkg` holds the source enum (`SRC_MISS = 0`, `SRC_UC = 1`) and the default widths.
- Sub-module `dmem_arb_order_fifo`: DEPTH x 1-bit synchronous FIFO with asynchronous active-high reset, and push, pop, head, full, empty and count outputs.
- The top level contains the arbiter, lock registers, muxes and error flag.

## Test plan
- Single source: miss reads addr 0x8000_0040, id 3, len 1; the downstream returns 2 beats, last on beat 2. Expect 2 beats on `resp_valid_o[0]` only, `resp_id_o = 3`, `outstanding_o` going 1→0, and `err_o = 0`.
- Contention: both sources request every cycle with `dn_req_ready_i = 1`. Expect grants in the order 0,1,0,1 after reset, and each source's FIFO entry matching the order of its responses.
- Backpressure lock: uc requests while `dn_req_ready_i = 0` for 3 cycles, and miss raises its request in cycle 2. Expect uc fields to stay stable on `dn_req_*` until accepted; miss is granted the next cycle.
- Full: with DEPTH = 4, issue 4 requests with no responses. Expect `outstanding_o = 4` and both `req_ready_o = 0`. One last-beat response then gives `outstanding_o = 3`, and the request is accepted one cycle later.
- Response backpressure: the head is uc and `resp_ready_i[1] = 0` for 2 cycles. Expect `dn_resp_ready_o = 0`, data held, and no pop until ready.
- Error and reset: a response arrives with the FIFO empty, so expect `err_o = 1`. Asserting `rst_i` mid-operation clears `err_o`, `outstanding_o` and `rr_q` immediately.
